// File: rtl/compar_search_pkg.sv
// Shared types and constants for the compar_search binary-search controller.
// Contents:
//   state_t  - controller states (IDLE, PROBE, DONE)
//   FLAG_*   - legal one-hot comparator flag vectors, ordered {y1, y2, y3}
package compar_search_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // {y1, y2, y3} = {a > b, a == b, a < b}
  localparam logic [2:0] FLAG_GT = 3'b100;
  localparam logic [2:0] FLAG_EQ = 3'b010;
  localparam logic [2:0] FLAG_LT = 3'b001;

endpackage

// File: rtl/compar3bit.sv
// 3-bit combinational magnitude comparator used as the search target oracle.
// Ports:
//   a, b         - operands
//   y1 / y2 / y3 - a > b / a == b / a < b
module compar3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       y1,
  output logic       y2,
  output logic       y3
);

  assign y1 = (a > b);
  assign y2 = (a == b);
  assign y3 = (a < b);

endmodule

// File: rtl/compar_search.sv
// Binary-search initiator for the magnitude comparator: drives a probe value
// on the comparator's a input and narrows [lo, hi] from the y1/y2/y3 flags
// until the value on b is located or the range is exhausted.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   start              - begin a new search (honoured only in IDLE)
//   guess              - current probe value (comparator a)
//   y1, y2, y3         - comparator flags a>b, a==b, a<b
//   busy               - high while probing
//   done               - one-cycle pulse when a search ends
//   found, err, result - outcome, held until the next accepted start
//   steps              - probes issued in the last or current search
module compar_search
  import compar_search_pkg::*;
#(
  parameter int unsigned W  = 3,
  parameter int unsigned SW = $clog2(W + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [W-1:0]  guess,
  input  logic          y1,
  input  logic          y2,
  input  logic          y3,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          err,
  output logic [W-1:0]  result,
  output logic [SW-1:0] steps
);

  localparam logic [W-1:0]  MAX_VAL   = {W{1'b1}};
  localparam logic [W-1:0]  FIRST_MID = MAX_VAL >> 1;
  localparam logic [SW-1:0] STEPS_MAX = {SW{1'b1}};

  state_t        state, state_d;
  logic [W-1:0]  lo, hi, lo_d, hi_d;
  logic [W-1:0]  guess_d, result_d;
  logic [SW-1:0] steps_d;
  logic          busy_d, done_d, found_d, err_d;

  logic [2:0]    flags;
  logic [W:0]    sum_dn, sum_up;
  logic [W-1:0]  mid_dn, mid_up;

  assign flags = {y1, y2, y3};

  // Midpoints of the shrunken ranges, summed one bit wider so they never overflow.
  assign sum_dn = (W+1)'(lo) + (W+1)'(guess) - (W+1)'(1);
  assign sum_up = (W+1)'(guess) + (W+1)'(1) + (W+1)'(hi);
  assign mid_dn = W'(sum_dn >> 1);
  assign mid_up = W'(sum_up >> 1);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      steps  <= '0;
    end else begin
      state  <= state_d;
      lo     <= lo_d;
      hi     <= hi_d;
      guess  <= guess_d;
      busy   <= busy_d;
      done   <= done_d;
      found  <= found_d;
      err    <= err_d;
      result <= result_d;
      steps  <= steps_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    lo_d     = lo;
    hi_d     = hi;
    guess_d  = guess;
    busy_d   = busy;
    done_d   = 1'b0;
    found_d  = found;
    err_d    = err;
    result_d = result;
    steps_d  = steps;

    case (state)
      IDLE: begin
        if (start) begin
          state_d  = PROBE;
          lo_d     = '0;
          hi_d     = MAX_VAL;
          guess_d  = FIRST_MID;
          steps_d  = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          busy_d   = 1'b1;
        end
      end

      PROBE: begin
        // Saturating count: the search ends within W+1 probes anyway.
        steps_d = (steps == STEPS_MAX) ? steps : steps + SW'(1);

        if ((flags != FLAG_GT) && (flags != FLAG_EQ) && (flags != FLAG_LT)) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          busy_d  = 1'b0;
          state_d = DONE;
        end else if (flags == FLAG_EQ) begin
          found_d  = 1'b1;
          result_d = guess;
          busy_d   = 1'b0;
          state_d  = DONE;
        end else if (flags == FLAG_GT) begin
          // Target lies below the probe; an empty lower half means not found.
          if (guess == lo) begin
            found_d = 1'b0;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            hi_d    = guess - W'(1);
            guess_d = mid_dn;
          end
        end else begin
          // Target lies above the probe; an empty upper half means not found.
          if (guess == hi) begin
            found_d = 1'b0;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            lo_d    = guess + W'(1);
            guess_d = mid_up;
          end
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_compar_search.sv
// Self-checking bench for compar_search driving a real compar3bit, with an
// optional override of the comparator flags for fault-style scenarios.
module tb_compar_search;

  localparam int unsigned W  = 3;
  localparam int unsigned SW = $clog2(W + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  guess;
  logic [W-1:0]  target;
  logic          y1, y2, y3;
  logic          cy1, cy2, cy3;
  logic          busy, done, found, err;
  logic [W-1:0]  result;
  logic [SW-1:0] steps;
  logic          force_en;
  logic [2:0]    force_flags;

  always #5 clk = ~clk;

  compar3bit u_cmp (
    .a  (guess),
    .b  (target),
    .y1 (cy1),
    .y2 (cy2),
    .y3 (cy3)
  );

  assign y1 = force_en ? force_flags[2] : cy1;
  assign y2 = force_en ? force_flags[1] : cy2;
  assign y3 = force_en ? force_flags[0] : cy3;

  compar_search #(.W(W), .SW(SW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .guess  (guess),
    .y1     (y1),
    .y2     (y2),
    .y3     (y3),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result),
    .steps  (steps)
  );

  int checks = 0;
  int errors = 0;

  int got_probes[$];
  int exp_probes[$];
  int got_found, got_err, got_result, got_steps, got_busy, got_done_edge, got_done_after;
  int exp_found, exp_result;

  typedef struct {
    int target;
    int exp_steps;
    int exp_result;
    int exp_found;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: textbook binary search over 0..2^W-1.
  // mode 0: real comparison against tgt; 1: target always above; 2: always below.
  task automatic model_search(input int mode, input int tgt);
    int lo, hi, g, rel;
    lo = 0;
    hi = (1 << W) - 1;
    g = hi / 2;
    exp_probes.delete();
    exp_found = 0;
    exp_result = 0;
    for (int k = 0; k < 16; k++) begin
      exp_probes.push_back(g);
      if (mode == 0) rel = (g > tgt) ? 1 : ((g == tgt) ? 0 : -1);
      else if (mode == 1) rel = -1;
      else rel = 1;
      if (rel == 0) begin
        exp_found = 1;
        exp_result = g;
        break;
      end else if (rel > 0) begin
        if (g == lo) break;
        hi = g - 1;
      end else begin
        if (g == hi) break;
        lo = g + 1;
      end
      g = (lo + hi) / 2;
    end
  endtask

  // Launch one search and record probes, busy length, done timing and outcome.
  task automatic run_search(input bit hold_start);
    got_probes.delete();
    got_busy = 0;
    got_done_edge = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      start = hold_start && (c == 1 || c == 2);
      if (busy) begin
        got_probes.push_back(int'(guess));
        got_busy++;
      end
      if (done) begin
        got_done_edge = c;
        break;
      end
    end
    start = 1'b0;
    if (got_done_edge < 0) check("done_timeout", 0, 1);
    got_found  = int'(found);
    got_err    = int'(err);
    got_result = int'(result);
    got_steps  = int'(steps);
    @(posedge clk);
    #1;
    got_done_after = int'(done);
    check("result_held", int'(result), got_result);
  endtask

  task automatic compare_to_model(input string tag);
    check({tag, "_nprobes"}, got_probes.size(), exp_probes.size());
    for (int i = 0; i < exp_probes.size() && i < got_probes.size(); i++)
      check({tag, "_probe"}, got_probes[i], exp_probes[i]);
    check({tag, "_found"}, got_found, exp_found);
    check({tag, "_result"}, got_result, exp_result);
    check({tag, "_err"}, got_err, 0);
    check({tag, "_steps"}, got_steps, exp_probes.size());
    check({tag, "_busy_len"}, got_busy, exp_probes.size());
    check({tag, "_done_edge"}, got_done_edge, exp_probes.size() + 1);
    check({tag, "_done_pulse"}, got_done_after, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_guess"}, int'(guess), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_found"}, int'(found), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_steps"}, int'(steps), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int mode, tgt;

    vecs[0] = '{0, 3, 0, 1};
    vecs[1] = '{1, 2, 1, 1};
    vecs[2] = '{2, 3, 2, 1};
    vecs[3] = '{3, 1, 3, 1};
    vecs[4] = '{4, 3, 4, 1};
    vecs[5] = '{5, 2, 5, 1};
    vecs[6] = '{6, 3, 6, 1};
    vecs[7] = '{7, 4, 7, 1};

    rst = 1'b1;
    start = 1'b0;
    force_en = 1'b0;
    force_flags = 3'b000;
    target = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("idle");

    // Every target with hand-derived outcomes, plus probe order from the model.
    for (int i = 0; i < 8; i++) begin
      target = W'(vecs[i].target);
      run_search(1'b0);
      check("tbl_steps", got_steps, vecs[i].exp_steps);
      check("tbl_result", got_result, vecs[i].exp_result);
      check("tbl_found", got_found, vecs[i].exp_found);
      check("tbl_err", got_err, 0);
      check("tbl_done_edge", got_done_edge, vecs[i].exp_steps + 1);
      check("tbl_busy_len", got_busy, vecs[i].exp_steps);
      model_search(0, vecs[i].target);
      compare_to_model("tbl");
    end

    // Illegal flags y1 & y3 on the first probe.
    force_en = 1'b1;
    force_flags = 3'b101;
    run_search(1'b0);
    check("multi_done_edge", got_done_edge, 2);
    check("multi_err", got_err, 1);
    check("multi_found", got_found, 0);
    check("multi_result", got_result, 0);
    check("multi_steps", got_steps, 1);
    check("multi_nprobes", got_probes.size(), 1);

    // No flag asserted at all.
    force_flags = 3'b000;
    run_search(1'b0);
    check("none_err", got_err, 1);
    check("none_steps", got_steps, 1);

    // Target always above: walks to the top and gives up at guess==hi.
    force_flags = 3'b001;
    run_search(1'b0);
    check("above_nprobes", got_probes.size(), 4);
    if (got_probes.size() == 4) begin
      check("above_p0", got_probes[0], 3);
      check("above_p1", got_probes[1], 5);
      check("above_p2", got_probes[2], 6);
      check("above_p3", got_probes[3], 7);
    end
    check("above_found", got_found, 0);
    check("above_err", got_err, 0);
    check("above_steps", got_steps, 4);
    force_en = 1'b0;

    // Reset during the second probe of a b=7 search.
    target = 3'd7;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("rstmid_probe1", int'(guess), 3);
    @(posedge clk);
    #1;
    check("rstmid_probe2", int'(guess), 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("rstmid");
    @(posedge clk);
    #1;
    check("rstmid_stays_idle", int'(busy), 0);

    // start asserted while busy must not disturb the search.
    run_search(1'b1);
    model_search(0, 7);
    compare_to_model("busy_start");
    check("busy_start_idle", int'(busy), 0);

    // Randomized searches against the model.
    for (int r = 0; r < 30; r++) begin
      mode = int'($urandom_range(0, 2));
      tgt = int'($urandom_range(0, (1 << W) - 1));
      target = W'(tgt);
      force_en = (mode != 0);
      force_flags = (mode == 1) ? 3'b001 : 3'b100;
      model_search(mode, tgt);
      run_search(1'b0);
      compare_to_model("rand");
    end
    force_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
